// File: rtl/censor_mask_gen_if.sv
// censor_mask_gen_if: stream and configuration bundle for censor_mask_gen.
//   master : character source / downstream observer (drives in_valid, in_char, pattern, pat_len)
//   slave  : censor_mask_gen (drives in_ready, char_out, mask_bit, out_valid, busy)
// Signals:
//   in_valid/in_char/in_ready : byte stream in, 0x00 terminates a string
//   pattern/pat_len           : forbidden word, byte 0 first; pat_len 0 disables matching
//   char_out/mask_bit/out_valid : released character, its mask bit, one-cycle strobe
//   busy                      : buffer occupied or flush in progress
interface censor_mask_gen_if #(
  parameter int MAX_LEN = 8
);
  localparam int LW = $clog2(MAX_LEN + 1);

  logic                 in_valid;
  logic [7:0]           in_char;
  logic                 in_ready;
  logic [8*MAX_LEN-1:0] pattern;
  logic [LW-1:0]        pat_len;
  logic [7:0]           char_out;
  logic                 mask_bit;
  logic                 out_valid;
  logic                 busy;

  modport master (
    output in_valid, in_char, pattern, pat_len,
    input  in_ready, char_out, mask_bit, out_valid, busy
  );

  modport slave (
    input  in_valid, in_char, pattern, pat_len,
    output in_ready, char_out, mask_bit, out_valid, busy
  );
endinterface

// File: rtl/censor_mask_gen.sv
// censor_mask_gen: sliding-window forbidden-word detector in front of the
// censor masking stage. Characters pass through a MAX_LEN-deep shift buffer;
// whenever the newest pat_len characters equal the pattern, all of them get
// their mask bit set. A 0x00 terminator flushes the buffer and is then
// forwarded as a zero character.
// Ports:
//   clk   : clock, posedge
//   rst_n : synchronous active-low reset
//   bus   : censor_mask_gen_if.slave (stream in, pattern config, masked stream out, busy)
// Build option:
//   CENSOR_CASE_FOLD_EN : when defined, A-Z compare equal to a-z (stored
//                         characters are not altered).
//
// state | meaning
// RUN   | accepting characters, shift + match on each accept
// FLUSH | shifting bubbles in, draining the buffer (MAX_LEN cycles)
// TERM  | emitting the 0x00 terminator for one cycle
module censor_mask_gen #(
  parameter int MAX_LEN = 8
) (
  input logic              clk,
  input logic              rst_n,
  censor_mask_gen_if.slave bus
);
  localparam int LW = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {RUN, FLUSH, TERM} state_t;

  state_t               state_q, state_d;
  logic [LW-1:0]        flush_cnt_q;
  logic [7:0]           s_char [MAX_LEN];
  logic [MAX_LEN-1:0]   s_mask, s_occ;
  logic [7:0]           char_out_q;
  logic                 mask_q, valid_q;

  logic                 in_ready;
  logic                 shift_run, shift_flush, load_flush, emit_term;

  logic [7:0]           pat_b [MAX_LEN];
  logic [7:0]           win_char [MAX_LEN];
  logic [MAX_LEN-1:0]   win_occ;
  logic [MAX_LEN-1:0]   hit_mask;
  logic [7:0]           exp_b;
  logic                 match;
  int                   len_i;

  function automatic logic [7:0] fold(input logic [7:0] c);
`ifdef CENSOR_CASE_FOLD_EN
    if (c >= 8'h41 && c <= 8'h5A) return c | 8'h20;
`endif
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    in_ready    = 1'b0;
    shift_run   = 1'b0;
    shift_flush = 1'b0;
    load_flush  = 1'b0;
    emit_term   = 1'b0;
    case (state_q)
      RUN: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          if (bus.in_char != 8'h00) begin
            shift_run = 1'b1;
          end else begin
            load_flush = 1'b1;
            state_d    = FLUSH;
          end
        end
      end
      FLUSH: begin
        shift_flush = 1'b1;
        if (flush_cnt_q == LW'(1)) state_d = TERM;
      end
      TERM: begin
        emit_term = 1'b1;
        state_d   = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Window as it will look after this accept: in_char in front of the
  // current buffer. Matching against it lets the mask land in the same
  // register update as the shift.
  always_comb begin
    win_char[0] = bus.in_char;
    for (int i = 1; i < MAX_LEN; i++) win_char[i] = s_char[i-1];
    win_occ = {s_occ[MAX_LEN-2:0], 1'b1};
    for (int k = 0; k < MAX_LEN; k++) pat_b[k] = bus.pattern[8*k +: 8];
  end

  always_comb begin
    len_i = int'(bus.pat_len);
    if (len_i > MAX_LEN) len_i = 0;
    match    = (len_i != 0);
    exp_b    = 8'h00;
    hit_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < len_i) begin
        // Window stage i lines up with pattern byte len-1-i (oldest = byte 0).
        exp_b = 8'h00;
        for (int k = 0; k < MAX_LEN; k++) begin
          if (k + i + 1 == len_i) exp_b = pat_b[k];
        end
        if (!win_occ[i] || fold(win_char[i]) != fold(exp_b)) match = 1'b0;
      end
    end
    for (int i = 0; i < MAX_LEN; i++) hit_mask[i] = match && (i < len_i);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LEN; i++) s_char[i] <= 8'h00;
      s_mask      <= '0;
      s_occ       <= '0;
      flush_cnt_q <= '0;
      char_out_q  <= 8'h00;
      mask_q      <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (shift_run || shift_flush) begin
        for (int i = 1; i < MAX_LEN; i++) s_char[i] <= s_char[i-1];
        // Flush shifts in bubbles with a zero char so stale data never lingers.
        s_char[0]  <= shift_run ? bus.in_char : 8'h00;
        s_occ      <= {s_occ[MAX_LEN-2:0], shift_run};
        s_mask     <= {s_mask[MAX_LEN-2:0], 1'b0} | (shift_run ? hit_mask : '0);
        char_out_q <= s_char[MAX_LEN-1];
        mask_q     <= s_mask[MAX_LEN-1];
        valid_q    <= s_occ[MAX_LEN-1];
      end else if (emit_term) begin
        char_out_q <= 8'h00;
        mask_q     <= 1'b0;
        valid_q    <= 1'b1;
      end
      if (load_flush)       flush_cnt_q <= LW'(MAX_LEN);
      else if (shift_flush) flush_cnt_q <= flush_cnt_q - LW'(1);
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.char_out  = char_out_q;
  assign bus.mask_bit  = mask_q;
  assign bus.out_valid = valid_q;
  assign bus.busy      = (|s_occ) || (state_q != RUN);

endmodule

// File: tb/tb_censor_mask_gen.sv
// tb_censor_mask_gen: directed-vector bench for censor_mask_gen (MAX_LEN=8).
// Emitted {mask,char} pairs are collected and compared against hand-written
// expected sequences. Honors CENSOR_CASE_FOLD_EN for the case-fold vector.
module tb_censor_mask_gen;
  localparam int MAX_LEN = 8;
  localparam int LW      = $clog2(MAX_LEN + 1);
`ifdef CENSOR_CASE_FOLD_EN
  localparam bit FOLD = 1'b1;
`else
  localparam bit FOLD = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  censor_mask_gen_if #(.MAX_LEN(MAX_LEN)) bus ();
  censor_mask_gen #(.MAX_LEN(MAX_LEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [8:0] got_q [$];
  logic [8:0] exp_q [$];

  always @(posedge clk) begin
    #1;
    if (bus.out_valid === 1'b1) got_q.push_back({bus.mask_bit, bus.char_out});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_pat(input string s, input int len);
    bus.pattern = '0;
    for (int k = 0; k < s.len(); k++) bus.pattern[8*k +: 8] = s[k];
    bus.pat_len = LW'(len);
  endtask

  task automatic send(input logic [7:0] c);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_char  = c;
    for (int n = 0; n < 40; n++) begin
      if (bus.in_ready === 1'b1) begin
        @(posedge clk);
        return;
      end
      @(negedge clk);
    end
    check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic exp_str(input string s, input logic m);
    for (int i = 0; i < s.len(); i++) exp_q.push_back({m, s[i]});
  endtask

  task automatic compare(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_item%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  // Sends the terminator, counts in_ready-low cycles, then checks the stream.
  task automatic terminate(input string tag);
    int low;
    send(8'h00);
    idle();
    low = 0;
    for (int n = 0; n < 40; n++) begin
      if (bus.in_ready === 1'b1) break;
      low++;
      @(negedge clk);
    end
    check({tag, "_rdy_low"}, 32'(low), 32'd9);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    exp_q.push_back(9'h000);
    compare(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 1'b1;
    bus.in_char  = "z";
    set_pat("bad", 3);

    repeat (3) begin
      @(negedge clk);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_busy",      32'(bus.busy),      32'd0);
      check("rst_char_out",  32'(bus.char_out),  32'd0);
      check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    end
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    check("rst_no_emit", 32'(got_q.size()), 32'd0);

    // Basic mask with latency checks around the 9th accept.
    send_str("xbadyyyy");
    idle();
    check("lat_before_9th", 32'(got_q.size()), 32'd0);
    send("y");
    idle();
    check("lat_at_9th", 32'(got_q.size()), 32'd1);
    send_str("yyy");
    exp_str("x", 1'b0);
    exp_str("bad", 1'b1);
    exp_str("yyyyyyyy", 1'b0);
    terminate("basic");

    exp_str("hi", 1'b0);
    send_str("hi");
    terminate("flush");

    set_pat("aa", 2);
    exp_str("aaa", 1'b1);
    exp_str("b", 1'b0);
    send_str("aaab");
    terminate("overlap");

    set_pat("bad", 3);
    exp_str("BaD", FOLD);
    send_str("BaD");
    terminate("casefold");

    set_pat("bad", 0);
    exp_str("bad", 1'b0);
    send_str("bad");
    terminate("disabled");

    set_pat("bad", 9);
    exp_str("bad", 1'b0);
    send_str("bad");
    terminate("len_over");

    // Reset pulsed on the 2nd FLUSH cycle discards everything.
    set_pat("bad", 0);
    send_str("bad");
    send(8'h00);
    idle();
    check("mid_rst_flush_rdy", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_rdy",  32'(bus.in_ready), 32'd1);
    check("mid_rst_busy", 32'(bus.busy),     32'd0);
    repeat (14) @(negedge clk);
    check("mid_rst_no_emit",  32'(got_q.size()), 32'd0);
    check("mid_rst_rdy_late", 32'(bus.in_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/censor_mask_gen.md
# censor_mask_gen

Upstream stage of the censor output path. It accepts a byte stream, keeps a sliding window of the newest characters, and compares it against a programmable forbidden pattern. Every character is marked with a mask bit and released in order, as a character plus mask-bit pair, to the masking/output-select stage. A 0x00 terminator flushes the window and is then forwarded, so the downstream stage sees end-of-string as a zero character.

## Interface
- MAX_LEN, 8: window depth in characters, and the maximum pattern length (≥2).
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  in_char is valid this cycle.
- in_char  in  8  input byte; 0x00 is the terminator.
- in_ready  out  1  block accepts in_char this cycle.
- pattern  in  8*MAX_LEN  forbidden word.
  - byte k is bits [8k+7:8k].
  - byte 0 is the first character of the word.
- pat_len  in  $clog2(MAX_LEN+1)  pattern length.
  - 0 disables matching.
  - Values above MAX_LEN are treated as 0.
- char_out  out  8  released character.
- mask_bit  out  1  1 = char_out belongs to a matched word.
- out_valid  out  1  char_out/mask_bit valid this cycle (single-cycle strobe).
- busy  out  1  buffer holds ≥1 character, or a flush is in progress.

## Operation
- Storage: MAX_LEN stages, s[0] (newest) to s[MAX_LEN-1] (oldest). Each stage holds {char, mask, occ}.
- FSM states: RUN, FLUSH, TERM. Reset enters RUN.
- RUN: in_ready=1.
  - Accept = in_valid & in_ready.
  - Accepted non-zero char:
    - Shift all stages by one; the char enters s[0] with occ=1.
    - The entry displaced from s[MAX_LEN-1] is emitted; out_valid equals its occ bit.
    - Match: with L=pat_len, the post-shift chars s[L-1..0] equal pattern bytes 0..L-1 (s[L-1] = byte 0).
    - On a match, the mask bits of s[0..L-1] are set. The set is ORed with existing masks, so overlapping and adjacent matches are all masked.
  - Accepted 0x00: no shift; go to FLUSH, with flush counter = MAX_LEN.
- FLUSH: in_ready=0.
  - Each cycle, shift a bubble (occ=0) into s[0] and emit the displaced entry; out_valid equals its occ bit.
  - No matching is done during FLUSH.
  - After MAX_LEN cycles, go to TERM.
- TERM: in_ready=0.
  - Output char_out=0x00, mask_bit=0, out_valid=1 for one cycle.
  - Then go to RUN. The buffer is empty at this point.
- pattern and pat_len are sampled every accept. They must be held stable while busy=1; a change mid-word gives undefined masking for that word only.
- Characters are never dropped, reordered or altered. Only mask_bit is added.

## Timing
- Reset values: char_out=0x00, mask_bit=0, out_valid=0, busy=0, in_ready=1, all stages occ=0 and mask=0.
- A reset asserted mid-operation, including during FLUSH or TERM, discards all buffered characters. No terminator is emitted.
- All outputs are registered and update one cycle after the accept or FLUSH cycle that caused them.
- Latency in RUN: a character is emitted on the accept of the MAX_LEN-th character after it.
- Flush: terminator accepted at cycle T.
  - Flush shifts occur at T+1..T+MAX_LEN; the flushed characters appear on the outputs one cycle after each shift.
  - The TERM state is at T+MAX_LEN+1, and the 0x00 appears on the outputs at T+MAX_LEN+2.
  - in_ready is 0 from T+1 to T+MAX_LEN+1 inclusive, and 1 again at T+MAX_LEN+2.
- in_valid while in_ready=0: in_char is ignored. The source must hold it until accepted.
- Match with accept on the same edge: the mask is applied in the same register update as the shift. A character displaced on that edge is never part of the current window.
- Idle cycles (in_valid=0 in RUN): no shift, out_valid=0, state held.

## Configuration
- CENSOR_CASE_FOLD_EN defined:
  - Before comparison, both the window characters and the pattern bytes map 0x41–0x5A to 0x61–0x7A.
  - Stored and emitted characters are unchanged.
- CENSOR_CASE_FOLD_EN undefined: exact 8-bit comparison.

## Test plan
All scenarios use MAX_LEN=8.
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 → out_valid=0, busy=0, char_out=0x00, in_ready=1 throughout.
- Basic mask: pattern "bad", pat_len=3; stream "xbadyyyyyyyy" → emitted in order: 'x' mask 0, 'b','a','d' mask 1, 'y' mask 0. 'x' is emitted on the 9th accept.
- Terminator flush: pattern "bad"; stream "hi",0x00 → in_ready low for exactly 9 cycles.
  - Emitted: 'h' m0, 'i' m0, then 0x00 m0.
  - busy then drops to 0 and in_ready returns to 1.
- Overlap: pattern "aa", pat_len=2; stream "aaab",0x00 → 'a','a','a' mask 1, 'b' mask 0, then 0x00.
- Case fold: pattern "bad"; stream "BaD",0x00 → mask 1 on all three with CENSOR_CASE_FOLD_EN, mask 0 without.
- Disable and reset mid-flush: with pat_len=0, stream "bad",0x00 → all mask 0. Repeat, and pulse rst_n=0 on the 2nd FLUSH cycle → no further out_valid, in_ready=1 on the cycle after reset is released.
